// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants and state encoding for the fetch stage
package if_fetch_pkg;

  localparam int STALL_PC   = 0;
  localparam int STALL_IFID = 1;
  localparam int STALL_EX   = 2;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped one-word-per-line instruction cache
module icache_dm #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:2] lookup_addr,
  output logic        hit,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [31:2] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  assign rd_idx  = lookup_addr[IDX_W+1:2];
  assign wr_idx  = wr_addr[IDX_W+1:2];
  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == lookup_addr[31:IDX_W+2]);
  assign rd_data = data_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_addr[31:IDX_W+2];
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, icache lookup, byte-wide miss fill
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IDX_W    = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [2:0]  stall_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        mem_ack,
  input  logic [7:0]  mem_din,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [2:0]  stall_IF,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [23:0]  bytes_q, bytes_d;
  logic         mem_req_d;
  logic [31:0]  mem_addr_d;
  logic [31:0]  if_pc_d, if_inst_d;
  logic         if_valid_d;

  logic         hit;
  logic [31:0]  hit_data;
  logic         cache_we;
  logic [31:0]  fill_word;
  logic         word_done;
  logic [31:0]  word_data;

  logic         unused_ok;
  assign unused_ok = ^{br_target[1:0], stall_in[STALL_EX]};

  assign fill_word = {mem_din, bytes_q};
  assign stall_IF  = (state_q == FETCH) ? 3'b001 : 3'b000;

  icache_dm #(.IDX_W(IDX_W)) u_icache (
    .clk         (clk_in),
    .rst_n       (rst_in),
    .lookup_addr (pc_q[31:2]),
    .hit         (hit),
    .rd_data     (hit_data),
    .wr_en       (cache_we),
    .wr_addr     (pc_q[31:2]),
    .wr_data     (fill_word)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    bytes_d    = bytes_q;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    if_pc_d    = if_pc;
    if_inst_d  = if_inst;
    if_valid_d = if_valid;
    cache_we   = 1'b0;
    word_done  = 1'b0;
    word_data  = hit_data;

    if (rdy_in) begin
      if (br_taken) begin
        // Redirect wins over everything; any partial fill is abandoned.
        pc_d       = {br_target[31:2], 2'b00};
        if_valid_d = 1'b0;
        state_d    = IDLE;
        cnt_d      = '0;
        mem_req_d  = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!stall_in[STALL_PC]) begin
              if (hit) begin
                word_done = 1'b1;
                word_data = hit_data;
                pc_d      = pc_q + 32'd4;
              end else begin
                state_d    = FETCH;
                cnt_d      = '0;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_q;
              end
            end
          end
          FETCH: begin
            if (mem_ack) begin
              case (cnt_q)
                2'd0:    bytes_d[7:0]   = mem_din;
                2'd1:    bytes_d[15:8]  = mem_din;
                2'd2:    bytes_d[23:16] = mem_din;
                default: ;
              endcase
              cnt_d      = cnt_q + 2'd1;
              mem_addr_d = pc_q + {30'b0, cnt_q} + 32'd1;
              if (cnt_q == 2'd3) begin
                cache_we  = 1'b1;
                word_done = 1'b1;
                word_data = fill_word;
                pc_d      = pc_q + 32'd4;
                mem_req_d = 1'b0;
                state_d   = IDLE;
              end
            end
          end
          default: state_d = IDLE;
        endcase

        if (!stall_in[STALL_IFID]) begin
          if_valid_d = word_done;
          if (word_done) begin
            if_pc_d   = pc_q;
            if_inst_d = word_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      bytes_q  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      bytes_q  <= bytes_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      if_pc    <= if_pc_d;
      if_inst  <= if_inst_d;
      if_valid <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed scoreboard bench for if_fetch
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [2:0]  stall_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mem_ack;
  logic [7:0]  mem_din;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [2:0]  stall_IF;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } word_t;

  word_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  if_fetch #(.RESET_PC(32'h0000_0000), .IDX_W(4)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .stall_in  (stall_in),
    .br_taken  (br_taken),
    .br_target (br_target),
    .mem_ack   (mem_ack),
    .mem_din   (mem_din),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .stall_IF  (stall_IF),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_valid  (if_valid)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] inst_at(input logic [31:0] pc);
    if (pc == 32'h0) return 32'h0050_0013;
    return {pc[15:0] ^ 16'h1234, ~pc[15:0]};
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] addr);
    logic [31:0] w;
    w = inst_at({addr[31:2], 2'b00});
    return w[8*addr[1:0] +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic push_word(input logic [31:0] pc);
    word_t w;
    w.pc   = pc;
    w.inst = inst_at(pc);
    exp_q.push_back(w);
  endtask

  task automatic check_word(input string tag);
    word_t w;
    chk({tag, ".valid"}, 32'(if_valid), 32'd1);
    n_vec++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s.sb: observed empty scoreboard expected a queued word", tag);
    end
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk({tag, ".pc"}, if_pc, w.pc);
      chk({tag, ".inst"}, if_inst, w.inst);
    end
  endtask

  task automatic serve_beats(input logic [31:0] pc, input int first);
    for (int i = first; i < 4; i++) begin
      chk("beat.addr", mem_addr, pc + 32'(i));
      chk("beat.stall", 32'(stall_IF), 32'd1);
      chk("beat.req", 32'(mem_req), 32'd1);
      mem_ack = 1'b1;
      mem_din = byte_at(pc + 32'(i));
      if (i == 3 && !stall_in[1]) push_word(pc);
      tick();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; stall_in = 3'b001;
    br_taken = 1'b0; br_target = '0; mem_ack = 1'b0; mem_din = '0;
    tick(); tick();

    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.if_pc", if_pc, 32'd0);
    chk("rst.if_inst", if_inst, 32'd0);
    chk("rst.valid", 32'(if_valid), 32'd0);
    chk("rst.stall", 32'(stall_IF), 32'd0);
    chk("rst.pc", dut.pc_q, 32'd0);

    // cold miss at 0
    stall_in = 3'b000; rst_in = 1'b1;
    tick();
    serve_beats(32'h0, 0);
    check_word("cold");
    chk("cold.pc", dut.pc_q, 32'd4);
    chk("cold.stall", 32'(stall_IF), 32'd0);
    chk("cold.req", 32'(mem_req), 32'd0);

    // warm hit after redirect back to 0
    br_taken = 1'b1; br_target = 32'h0; tick(); br_taken = 1'b0;
    chk("redir0.valid", 32'(if_valid), 32'd0);
    chk("redir0.req", 32'(mem_req), 32'd0);
    chk("redir0.pc", dut.pc_q, 32'd0);
    push_word(32'h0); tick();
    check_word("warm");
    chk("warm.req", 32'(mem_req), 32'd0);
    chk("warm.stall", 32'(stall_IF), 32'd0);

    // IF/ID held while the word at 4 completes
    stall_in = 3'b010; tick();
    chk("hold.valid0", 32'(if_valid), 32'd1);
    serve_beats(32'h4, 0);
    chk("hold.valid1", 32'(if_valid), 32'd1);
    chk("hold.inst", if_inst, 32'h0050_0013);
    chk("hold.if_pc", if_pc, 32'h0);
    chk("hold.pc", dut.pc_q, 32'd8);
    stall_in = 3'b011; tick(); tick();
    chk("pchold.pc", dut.pc_q, 32'd8);
    chk("pchold.req", 32'(mem_req), 32'd0);
    chk("pchold.valid", 32'(if_valid), 32'd1);
    stall_in = 3'b001; tick();
    chk("bubble.valid", 32'(if_valid), 32'd0);
    chk("bubble.pc", dut.pc_q, 32'd8);
    chk("bubble.req", 32'(mem_req), 32'd0);

    // redirect after two beats at 8; ack in redirect cycle dropped
    stall_in = 3'b000; tick();
    for (int i = 0; i < 2; i++) begin
      mem_ack = 1'b1; mem_din = byte_at(32'h8 + 32'(i)); tick();
    end
    chk("mid.addr", mem_addr, 32'hA);
    br_taken = 1'b1; br_target = 32'h0000_0102; mem_din = 8'hEE;
    tick();
    br_taken = 1'b0; mem_ack = 1'b0;
    chk("mid.req", 32'(mem_req), 32'd0);
    chk("mid.valid", 32'(if_valid), 32'd0);
    chk("mid.pc", dut.pc_q, 32'h100);
    chk("mid.stall", 32'(stall_IF), 32'd0);
    br_taken = 1'b1; br_target = 32'h8; tick(); br_taken = 1'b0;
    tick();
    chk("refetch8.req", 32'(mem_req), 32'd1);
    serve_beats(32'h8, 0);
    check_word("miss8");

    // lines 4 and 8 now hit back to back
    br_taken = 1'b1; br_target = 32'h4; tick(); br_taken = 1'b0;
    push_word(32'h4); tick();
    check_word("hit4");
    push_word(32'h8); tick();
    check_word("hit8");

    // rdy_in low mid-fill with a spurious ack
    br_taken = 1'b1; br_target = 32'h40; tick(); br_taken = 1'b0;
    tick();
    mem_ack = 1'b1; mem_din = byte_at(32'h40); tick();
    rdy_in = 1'b0; mem_din = 8'hEE;
    tick(); tick(); tick();
    chk("rdy.addr", mem_addr, 32'h41);
    chk("rdy.pc", dut.pc_q, 32'h40);
    chk("rdy.cnt", 32'(dut.cnt_q), 32'd1);
    chk("rdy.stall", 32'(stall_IF), 32'd1);
    rdy_in = 1'b1; mem_ack = 1'b0;
    serve_beats(32'h40, 1);
    check_word("rdy");

    // wrap at the top of the address space
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC; tick(); br_taken = 1'b0;
    tick();
    serve_beats(32'hFFFF_FFFC, 0);
    check_word("wrapmiss");
    chk("wrapmiss.pc", dut.pc_q, 32'd0);
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC; tick(); br_taken = 1'b0;
    push_word(32'hFFFF_FFFC); tick();
    check_word("wraphit");
    chk("wraphit.pc", dut.pc_q, 32'd0);

    // async reset in the middle of a fill (line 0 now holds 0x40)
    tick();
    chk("rstf.req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_din = byte_at(32'h0); tick(); mem_ack = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    chk("rstf.req0", 32'(mem_req), 32'd0);
    chk("rstf.valid", 32'(if_valid), 32'd0);
    chk("rstf.pc", dut.pc_q, 32'd0);
    chk("rstf.stall", 32'(stall_IF), 32'd0);
    chk("rstf.addr", mem_addr, 32'd0);
    tick();
    rst_in = 1'b1; tick();
    chk("rstf.coldagain", 32'(mem_req), 32'd1);
    chk("sb.empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
